// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared state encoding, default timing constants and width helper
package rotate_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DWELL, PAUSE} rot_state_t;

  localparam int unsigned DEF_PRESCALE    = 50_000_000;
  localparam int unsigned DEF_POSITIONS   = 8;
  localparam int unsigned DEF_LAPS        = 3;
  localparam int unsigned DEF_DWELL_TICKS = 2;

  // Counter width that stays at least one bit for degenerate counts of 1.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer plus edge register; pulses one clk per rising edge
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/rotate_sequencer.sv
// rtl/rotate_sequencer.sv - run/pause FSM, step prescaler, lap counting and dwell-before-reverse
module rotate_sequencer
  import rotate_pkg::*;
#(
  parameter int unsigned PRESCALE    = DEF_PRESCALE,
  parameter int unsigned POSITIONS   = DEF_POSITIONS,
  parameter int unsigned LAPS        = DEF_LAPS,
  parameter int unsigned DWELL_TICKS = DEF_DWELL_TICKS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_btn,
  input  logic                       dir_btn,
  input  logic                       auto_en,
  output logic                       step_en,
  output logic                       up,
  output logic [cw(POSITIONS)-1:0]   pos,
  output logic [cw(LAPS)-1:0]        lap_cnt,
  output logic                       running
);

  localparam int unsigned PW = cw(POSITIONS);
  localparam int unsigned LW = cw(LAPS);
  localparam int unsigned CW = cw(PRESCALE);
  localparam int unsigned DW = cw(DWELL_TICKS);

  localparam logic [PW-1:0] POS_MAX   = PW'(POSITIONS - 1);
  localparam logic [LW-1:0] LAP_MAX   = LW'(LAPS - 1);
  localparam logic [CW-1:0] PRE_MAX   = CW'(PRESCALE - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS - 1);

  logic start_pulse, dir_pulse;
  logic auto_s1, auto_s2;

  btn_sync_edge u_start (.clk(clk), .rst(rst), .din(start_btn), .pulse(start_pulse));
  btn_sync_edge u_dir   (.clk(clk), .rst(rst), .din(dir_btn),   .pulse(dir_pulse));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
    end else begin
      auto_s1 <= auto_en;
      auto_s2 <= auto_s1;
    end
  end

  rot_state_t    state, state_nx, saved, saved_nx;
  logic [CW-1:0] prescaler, pre_nx;
  logic [DW-1:0] dwell_cnt, dwell_nx;
  logic [PW-1:0] pos_nx, pos_adv;
  logic [LW-1:0] lap_nx;
  logic          up_nx, step_nx;
  logic          tick, at_wrap;

  assign tick    = (prescaler == PRE_MAX);
  assign at_wrap = up ? (pos == POS_MAX) : (pos == '0);
  assign pos_adv = up ? (at_wrap ? '0 : pos + 1'b1) : (at_wrap ? POS_MAX : pos - 1'b1);
  assign running = (state == RUN) || (state == DWELL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      saved     <= RUN;
      prescaler <= '0;
      dwell_cnt <= '0;
      pos       <= '0;
      lap_cnt   <= '0;
      up        <= 1'b1;
      step_en   <= 1'b0;
    end else begin
      state     <= state_nx;
      saved     <= saved_nx;
      prescaler <= pre_nx;
      dwell_cnt <= dwell_nx;
      pos       <= pos_nx;
      lap_cnt   <= lap_nx;
      up        <= up_nx;
      step_en   <= step_nx;
    end
  end

  // A start edge in RUN/DWELL freezes everything else that cycle, so the prescaler phase survives the pause.
  always_comb begin
    state_nx = state;
    saved_nx = saved;
    pre_nx   = prescaler;
    dwell_nx = dwell_cnt;
    pos_nx   = pos;
    lap_nx   = lap_cnt;
    up_nx    = up;
    step_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          state_nx = RUN;
          pre_nx   = '0;
        end
      end
      RUN: begin
        if (start_pulse) begin
          state_nx = PAUSE;
          saved_nx = RUN;
        end else begin
          pre_nx = tick ? '0 : prescaler + 1'b1;
          if (tick) begin
            step_nx = 1'b1;
            pos_nx  = pos_adv;
            if (at_wrap) begin
              if (lap_cnt == LAP_MAX) begin
                lap_nx = '0;
                if (auto_s2) state_nx = DWELL;
              end else begin
                lap_nx = lap_cnt + 1'b1;
              end
            end
          end
          if (dir_pulse) begin
            state_nx = DWELL;
            lap_nx   = '0;
          end
        end
      end
      DWELL: begin
        if (start_pulse) begin
          state_nx = PAUSE;
          saved_nx = DWELL;
        end else begin
          pre_nx = tick ? '0 : prescaler + 1'b1;
          if (tick) begin
            if (dwell_cnt == DWELL_MAX) begin
              dwell_nx = '0;
              up_nx    = ~up;
              state_nx = RUN;
            end else begin
              dwell_nx = dwell_cnt + 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (start_pulse) state_nx = saved;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb/tb_rotate_sequencer.sv - directed scenarios plus random button traffic against a behavioural model
module tb_rotate_sequencer;

  localparam int PRESCALE    = 4;
  localparam int POSITIONS   = 8;
  localparam int LAPS        = 2;
  localparam int DWELL_TICKS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic       dir_btn = 1'b0;
  logic       auto_en = 1'b0;
  logic       step_en, up, running;
  logic [2:0] pos;
  logic [0:0] lap_cnt;

  rotate_sequencer #(
    .PRESCALE(PRESCALE), .POSITIONS(POSITIONS), .LAPS(LAPS), .DWELL_TICKS(DWELL_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .dir_btn(dir_btn), .auto_en(auto_en),
    .step_en(step_en), .up(up), .pos(pos), .lap_cnt(lap_cnt), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 dwell, 3 paused; direction is +1/-1.
  int m_mode = 0, m_saved = 1, m_phase = 0, m_dwell = 0, m_pos = 0, m_lap = 0, m_dir = 1;
  bit m_step = 1'b0;
  bit hs[4], hd[4], ha[4];

  always @(posedge clk or negedge rst) begin : model
    bit s_ev, d_ev, a_lvl, tick, rev;
    if (!rst) begin
      m_mode = 0; m_saved = 1; m_phase = 0; m_dwell = 0;
      m_pos = 0; m_lap = 0; m_dir = 1; m_step = 1'b0;
      for (int i = 0; i < 4; i++) begin hs[i] = 0; hd[i] = 0; ha[i] = 0; end
    end else begin
      for (int i = 3; i > 0; i--) begin hs[i] = hs[i-1]; hd[i] = hd[i-1]; ha[i] = ha[i-1]; end
      hs[0] = start_btn; hd[0] = dir_btn; ha[0] = auto_en;
      s_ev  = hs[2] && !hs[3];
      d_ev  = hd[2] && !hd[3];
      a_lvl = ha[2];
      m_step = 1'b0;
      if (s_ev) begin
        if (m_mode == 0) begin m_mode = 1; m_phase = 0; end
        else if (m_mode == 3) m_mode = m_saved;
        else begin m_saved = m_mode; m_mode = 3; end
      end else if (m_mode == 1 || m_mode == 2) begin
        tick = (m_phase == PRESCALE - 1);
        m_phase = (m_phase + 1) % PRESCALE;
        if (m_mode == 1) begin
          rev = d_ev;
          if (tick) begin
            m_step = 1'b1;
            m_pos = (m_pos + m_dir + POSITIONS) % POSITIONS;
            if (m_pos == (m_dir > 0 ? 0 : POSITIONS - 1)) begin
              m_lap++;
              if (m_lap == LAPS) begin
                m_lap = 0;
                if (a_lvl) rev = 1'b1;
              end
            end
          end
          if (d_ev) m_lap = 0;
          if (rev) m_mode = 2;
        end else if (tick) begin
          m_dwell++;
          if (m_dwell == DWELL_TICKS) begin
            m_dwell = 0; m_dir = -m_dir; m_mode = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && rst) begin
      check("m_step_en", step_en, m_step);
      check("m_up", up, (m_dir > 0));
      check("m_pos", pos, m_pos);
      check("m_lap_cnt", lap_cnt, m_lap);
      check("m_running", running, (m_mode == 1 || m_mode == 2));
    end
  end

  task automatic wait_step(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_en !== 1'b1 && n < 64);
    check(tag, step_en, 1);
  endtask

  int n, cnt;
  logic up_b;

  initial begin
    #12;
    check("rst_step_en", step_en, 0);
    check("rst_up", up, 1);
    check("rst_pos", pos, 0);
    check("rst_lap", lap_cnt, 0);
    check("rst_running", running, 0);
    @(negedge clk);
    rst = 1'b1;
    model_on = 1'b1;

    // 1: start from IDLE, eight evenly spaced steps, one lap
    @(negedge clk); start_btn = 1'b1;
    @(negedge clk); @(negedge clk);
    check("t1_running_early", running, 0);
    @(negedge clk);
    check("t1_running", running, 1);
    start_btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wait_step("t1_step", n);
      check("t1_gap", n, 4);
      check("t1_pos", pos, i % 8);
    end
    check("t1_lap", lap_cnt, 1);

    // 2: auto-reverse after the second lap, two silent ticks, then counting down
    auto_en = 1'b1;
    for (int i = 0; i < 8; i++) wait_step("t2_step", n);
    check("t2_pos", pos, 0);
    check("t2_lap", lap_cnt, 0);
    wait_step("t2_after_dwell", n);
    check("t2_dwell_gap", n, 12);
    check("t2_up", up, 0);
    check("t2_pos7", pos, 7);
    wait_step("t2_next", n);
    check("t2_pos6", pos, 6);
    auto_en = 1'b0;

    // 3: manual reverse at pos 3
    cnt = 0;
    do begin wait_step("t3_seek", n); cnt++; end while (pos != 3'd3 && cnt < 10);
    check("t3_at3", pos, 3);
    dir_btn = 1'b1;
    repeat (3) @(negedge clk);
    dir_btn = 1'b0;
    check("t3_lap", lap_cnt, 0);
    check("t3_running", running, 1);
    wait_step("t3_step", n);
    check("t3_gap", 3 + n, 12);
    check("t3_up", up, 1);
    check("t3_pos", pos, 4);

    // 4: pause with prescaler at 1, resume keeps phase
    wait_step("t4_sync", n);
    repeat (3) @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    check("t4_pre_step", step_en, 1);
    @(negedge clk); @(negedge clk);
    start_btn = 1'b0;
    check("t4_paused", running, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step_en || running) cnt++;
    end
    check("t4_quiet", cnt, 0);
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
    check("t4_resumed", running, 1);
    @(negedge clk); check("t4_s1", step_en, 0);
    @(negedge clk); check("t4_s2", step_en, 0);
    @(negedge clk); check("t4_s3", step_en, 1);

    // 5: start and dir edges together -> pause only
    wait_step("t5_sync", n);
    up_b = up;
    start_btn = 1'b1; dir_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0; dir_btn = 1'b0;
    check("t5_paused", running, 0);
    repeat (10) @(negedge clk);
    check("t5_up_hold", up, up_b);
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    start_btn = 1'b0;
    check("t5_resumed", running, 1);
    wait_step("t5_step", n);
    check("t5_no_dwell", n <= PRESCALE, 1);
    check("t5_up", up, up_b);

    // 6: async reset mid-DWELL
    wait_step("t6_sync", n);
    dir_btn = 1'b1;
    repeat (5) @(negedge clk);
    dir_btn = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6_step_en", step_en, 0);
    check("t6_up", up, 1);
    check("t6_pos", pos, 0);
    check("t6_lap", lap_cnt, 0);
    check("t6_running", running, 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step_en) cnt++;
    end
    check("t6_no_step", cnt, 0);

    // random button, switch and reset traffic
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) start_btn = ~start_btn;
      if ($urandom_range(0, 99) < 1) dir_btn = ~dir_btn;
      if ($urandom_range(0, 199) < 1) auto_en = ~auto_en;
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst = 1'b0;
        #1;
        check("r_rst_pos", pos, 0);
        check("r_rst_running", running, 0);
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
